mem_copier: RTL
===============

MEM_COPIER -- requirements
Module: mem_copier

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 CLK  input  1  the only clock; all state SHALL update on posedge CLK.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  request a transfer; sampled only in IDLE.
REQ-006 Mode  input  1  transfer type: 0 = copy, 1 = fill.
REQ-007 SrcAddr  input  ADDR_W  copy source start address.
REQ-008 DstAddr  input  ADDR_W  destination start address.
REQ-009 Length  input  ADDR_W  byte count; 0 = no memory access.
REQ-010 FillValue  input  DATA_W  byte written in fill mode.
REQ-011 Abort  input  1  terminate the active transfer.
REQ-012 MemRData  input  DATA_W  read data from the data memory; combinational, valid in the same cycle as MemRead.
REQ-013 MemAddress  output  ADDR_W  data memory address.
REQ-014 MemRead  output  1  data memory read enable.
REQ-015 MemWrite  output  1  data memory write enable; the memory commits the write on posedge CLK.
REQ-016 MemWData  output  DATA_W  data memory write data.
REQ-017 Busy  output  1  high in READ and WRITE states.
REQ-018 Done  output  1  one-cycle completion pulse.
REQ-019 Remaining  output  ADDR_W  bytes not yet written.

Function
REQ-020 The block SHALL implement states IDLE, READ, WRITE and DONE.
- IDLE: on Start=1, latch SrcAddr, DstAddr, Length, Mode and FillValue.
  - Length=0 -> DONE.
  - Mode=0 -> READ.
  - Mode=1 -> WRITE.
REQ-021 In READ, the block SHALL drive MemRead=1 and MemAddress=src pointer, capture MemRData into a data register at the edge, then go to WRITE.
REQ-022 In WRITE, the block SHALL drive MemWrite=1, MemAddress=dst pointer and MemWData=data register (copy) or the latched FillValue (fill).
- At the edge: increment the pointers and decrement Remaining.
- Next state: DONE if Remaining was 1; otherwise READ (copy) or WRITE (fill).
REQ-023 In DONE, the block SHALL assert Done=1 for exactly one cycle, then go to IDLE.
REQ-024 MemRead and MemWrite SHALL never be high in the same cycle.
REQ-025 Outside their enabling state, outputs SHALL be driven to 0: MemRead=0, MemWrite=0, MemAddress=0, MemWData=0.
REQ-026 The memory-facing outputs SHALL be combinational decodes of registered state only, with no path from Start or Abort.
REQ-027 Latency from the Start edge to the Done pulse SHALL be:
- copy: 2N cycles of Busy, then Done;
- fill: N cycles of Busy, then Done;
- Length=0: Done in the first cycle after the Start edge, with no memory access.
REQ-028 Pointer arithmetic SHALL wrap modulo 2^ADDR_W (for example, 0xFF+1 = 0x00).
REQ-029 Overlapping copy regions SHALL be handled strictly forward, byte by byte; no overlap correction is applied.
REQ-030 Start SHALL be ignored in READ, WRITE and DONE.
REQ-031 Abort=1 sampled in READ or WRITE SHALL take the block to IDLE at that edge, with no Done pulse and Remaining cleared to 0.
- A write driven in that same WRITE cycle still commits.
REQ-032 Abort SHALL be ignored in IDLE and DONE.
REQ-033 If Start and Abort are both high in IDLE, Start SHALL win.
REQ-034 In IDLE, Remaining SHALL hold its last value.

Reset
REQ-035 Reset_n=0 SHALL immediately force:
- state IDLE;
- Busy=0, Done=0, MemRead=0, MemWrite=0;
- MemAddress=0, MemWData=0, Remaining=0;
- all pointers and the data register to 0.
REQ-036 Reset asserted mid-transfer SHALL abandon the transfer with no further memory access; bytes already written stay in memory.
REQ-037 After reset release, the first Start SHALL be sampled at the first posedge CLK on which Reset_n=1.

Verification
REQ-038 Copy: mem[0x10..0x13]=A1,B2,C3,D4; Start Mode=0 Src=0x10 Dst=0x80 Len=4
  -> 8 Busy cycles, alternating MemRead/MemWrite, then Done one cycle; mem[0x80..0x83]=A1,B2,C3,D4.
REQ-039 Fill with wrap: Mode=1 Dst=0xFE Len=3 Fill=0x5A
  -> writes at 0xFE, 0xFF, 0x00, each =5A; Busy for 3 cycles; Done; Remaining=0.
REQ-040 Length=0: Start Len=0
  -> Done in the next cycle; MemRead and MemWrite never asserted; Busy stays 0.
REQ-041 Abort: copy Len=5; Abort in the 2nd WRITE cycle
  -> exactly 2 bytes written; IDLE at the next cycle; no Done; Remaining=0.
REQ-042 Ignored Start: Start pulsed while Busy with different addresses
  -> the original transfer completes unchanged; no second transfer.
REQ-043 Async reset: Reset_n low mid-fill, between clock edges
  -> all outputs 0 immediately; a fresh Start after release runs correctly.

Source files
------------

// File: rtl/mem_copier_if.sv
// Data-memory bus between mem_copier (master) and a single-port memory (slave).
// MemRData is combinational from MemAddress in the same cycle as MemRead.
interface mem_copier_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] MemAddress;
  logic              MemRead;
  logic              MemWrite;
  logic [DATA_W-1:0] MemWData;
  logic [DATA_W-1:0] MemRData;

  modport master (
    output MemAddress,
    output MemRead,
    output MemWrite,
    output MemWData,
    input  MemRData
  );

  modport slave (
    input  MemAddress,
    input  MemRead,
    input  MemWrite,
    input  MemWData,
    output MemRData
  );
endinterface

// File: rtl/mem_copier.sv
// Byte copy / fill engine: copy alternates READ and WRITE per byte, fill writes every cycle.
// state | meaning
// IDLE  | waiting for Start; Remaining holds its last value
// READ  | fetch the byte at the source pointer into the data register
// WRITE | store one byte at the destination pointer, advance pointers
// DONE  | one-cycle completion pulse
module mem_copier #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Mode,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W-1:0] Length,
  input  logic [DATA_W-1:0] FillValue,
  input  logic              Abort,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] Remaining,
  mem_copier_if.master      memBus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            stateCur;
  state_t            stateNext;
  logic [ADDR_W-1:0] srcPtr;
  logic [ADDR_W-1:0] dstPtr;
  logic [DATA_W-1:0] dataReg;
  logic [DATA_W-1:0] fillValue;
  logic              fillMode;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      stateCur <= IDLE;
    end else begin
      stateCur <= stateNext;
    end
  end

  // Memory-facing outputs decode only registered state; Start/Abort only steer stateNext.
  always_comb begin
    stateNext         = stateCur;
    memBus.MemRead    = 1'b0;
    memBus.MemWrite   = 1'b0;
    memBus.MemAddress = '0;
    memBus.MemWData   = '0;
    Busy              = 1'b0;
    Done              = 1'b0;
    case (stateCur)
      IDLE: begin
        if (Start) begin
          if (Length == '0) begin
            stateNext = DONE;
          end else if (Mode) begin
            stateNext = WRITE;
          end else begin
            stateNext = READ;
          end
        end
      end
      READ: begin
        Busy              = 1'b1;
        memBus.MemRead    = 1'b1;
        memBus.MemAddress = srcPtr;
        stateNext         = Abort ? IDLE : WRITE;
      end
      WRITE: begin
        Busy              = 1'b1;
        memBus.MemWrite   = 1'b1;
        memBus.MemAddress = dstPtr;
        memBus.MemWData   = fillMode ? fillValue : dataReg;
        if (Abort) begin
          stateNext = IDLE;
        end else if (Remaining == ADDR_W'(1)) begin
          stateNext = DONE;
        end else begin
          stateNext = fillMode ? WRITE : READ;
        end
      end
      DONE: begin
        Done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      srcPtr    <= '0;
      dstPtr    <= '0;
      dataReg   <= '0;
      fillValue <= '0;
      fillMode  <= 1'b0;
      Remaining <= '0;
    end else begin
      case (stateCur)
        IDLE: begin
          if (Start) begin
            srcPtr    <= SrcAddr;
            dstPtr    <= DstAddr;
            Remaining <= Length;
            fillMode  <= Mode;
            fillValue <= FillValue;
          end
        end
        READ: begin
          if (Abort) begin
            Remaining <= '0;
          end else begin
            dataReg <= memBus.MemRData;
          end
        end
        WRITE: begin
          // An aborted write still commits in memory; only the count is cleared.
          if (Abort) begin
            Remaining <= '0;
          end else begin
            srcPtr    <= srcPtr + ADDR_W'(1);
            dstPtr    <= dstPtr + ADDR_W'(1);
            Remaining <= Remaining - ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
